// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Signed operands are converted to magnitudes at start. The unsigned product
// is built over XLEN cycles, and the sign is applied when the result is registered.
module mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] high,
    output logic [XLEN-1:0] low,
    output logic            busy,
    output logic            done
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_CALC | one shift-add step per edge, XLEN steps in total
    // S_DONE | result valid, done pulse; start here chains a new op
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(XLEN);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     mcand;
    logic [XLEN-1:0]     mplier;
    logic                res_neg;

    logic                in1_neg;
    logic                in2_neg;
    logic [XLEN-1:0]     in1_mag;
    logic [XLEN-1:0]     in2_mag;
    logic [XLEN:0]       add_sum;
    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   result;
    logic                cnt_last;

    // Operand sign handling and the single shift-add step.
    always_comb begin
        in1_neg  = (op != 2'b11) & in1[XLEN-1];
        in2_neg  = ~op[1] & in2[XLEN-1];
        in1_mag  = in1_neg ? -in1 : in1;
        in2_mag  = in2_neg ? -in2 : in2;
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mplier[0] ? mcand : {XLEN{1'b0}})};
        acc_next = {add_sum, acc[XLEN-1:1]};
        result   = res_neg ? -acc_next : acc_next;
        cnt_last = (cnt == CW'(XLEN - 1));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            high    <= '0;
            low     <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            res_neg <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand   <= in1_mag;
                        mplier  <= in2_mag;
                        res_neg <= in1_neg ^ in2_neg;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_CALC;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt_last) begin
                        high  <= result[2*XLEN-1:XLEN];
                        low   <= result[XLEN-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: a cycle-level reference model plus directed checks.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [31:0] high;
    logic [31:0] low;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    mul_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .high  (high),
        .low   (low),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference product: extend each operand according to its signedness,
    // then multiply in 64 bits.
    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = (o != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model. An op accepted at edge E gives done after edge E+32 and
    // busy after edges E..E+31. The next op may be accepted from edge E+33 on.
    int          m_cnt = 0;
    int          m_free_at = 0;
    int          m_start_e = -1000;
    int          m_done_e = -1000;
    logic [63:0] m_res = '0;
    logic [63:0] m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_free_at <= 0;
            m_start_e <= -1000;
            m_done_e  <= -1000;
            m_res     <= '0;
            m_out     <= '0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == m_done_e) m_out <= m_res;
            if (start && m_cnt >= m_free_at) begin
                m_res     <= ref_mul(op, in1, in2);
                m_start_e <= m_cnt;
                m_done_e  <= m_cnt + 32;
                m_free_at <= m_cnt + 33;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int last;
        last = m_cnt - 1;
        chk("cyc_busy", {63'b0, busy}, {63'b0, (last >= m_start_e) && (last < m_start_e + 32)});
        chk("cyc_done", {63'b0, done}, {63'b0, last == m_done_e});
        chk("cyc_result", {high, low}, m_out);
    end

    task automatic wait_done(output int edges, output int busy_cnt);
        edges = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
        end while (!done && edges < 100);
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    // Start an op, scramble the inputs after acceptance, and check the result.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit timing);
        int edges;
        int bcnt;
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        op    = 2'($urandom_range(0, 3));
        bcnt  = busy ? 1 : 0;
        begin
            int be;
            wait_done(edges, be);
            bcnt += be;
        end
        chk({name, "_result"}, {high, low}, exp);
        if (timing) begin
            chk({name, "_latency"}, 64'(edges), 64'd32);
            chk({name, "_busy_cycles"}, 64'(bcnt), 64'd32);
        end
        @(posedge clk);
        #1;
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin : guard
        #5ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    logic [31:0] corner [6];

    initial begin
        int e1;
        int e2;
        int bc;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'h0000_1234;

        // Hand-computed products that pin the reference function.
        chk("model_mulhu", ref_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_mulh_min", ref_mul(2'b01, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        chk("model_mul_neg", ref_mul(2'b00, 32'hFFFF_FFFF, 32'h0000_0007), 64'hFFFF_FFFF_FFFF_FFF9);
        chk("model_mulhsu", ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFF_0000_0001);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", {high, low}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
        do_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1);
        do_op("mul_m1x7", 2'b00, 32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9, 1);
        do_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 1);
        do_op("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1);

        // Back-to-back: start held through the first done.
        start = 1'b1;
        op    = 2'b11;
        in1   = 32'hFFFF_FFFF;
        in2   = 32'h0000_0002;
        @(posedge clk);
        #1;
        wait_done(e1, bc);
        chk("b2b_first_result", {high, low}, 64'h0000_0001_FFFF_FFFE);
        op  = 2'b00;
        in1 = 32'd3;
        in2 = 32'd5;
        e2  = 0;
        do begin
            @(posedge clk);
            #1;
            e2++;
            if (e2 == 3)  start = 1'b0;
            if (e2 == 10) start = 1'b1;
            if (e2 == 11) start = 1'b0;
            if (e2 == 20) start = 1'b1;
            if (e2 == 22) start = 1'b0;
        end while (!done && e2 < 100);
        chk("b2b_gap", 64'(e2), 64'd33);
        chk("b2b_second_result", {high, low}, 64'd15);
        @(posedge clk);
        #1;
        chk("b2b_back_idle", 64'(busy), 64'd0);

        // Reset abort in the middle of CALC.
        start = 1'b1;
        op    = 2'b00;
        in1   = 32'h1234_5678;
        in2   = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", {high, low}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) chk("abort_no_done", 64'(done), 64'd0);
        end
        do_op("mul_zero", 2'b00, 32'h0000_0000, 32'h0000_1234, 64'd0, 1);

        // Corner and random operands, with the expected values taken from the reference function.
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    if (((i + j + o) % 3) == 0)
                        do_op("corner", 2'(o), corner[i], corner[j], ref_mul(2'(o), corner[i], corner[j]), 0);
                end
            end
            for (int k = 0; k < 25; k++) begin
                logic [31:0] a;
                logic [31:0] b;
                a = $urandom;
                b = $urandom;
                do_op("random", 2'(o), a, b, ref_mul(2'(o), a, b), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
